mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between the instruction-fetch

---
 rtl/mips32_pkg.sv | 33 +++
 rtl/arb_starve_ctr.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// ---------------------------------------------------------------------------
// mips32_pkg
// Shared definitions for the mips32 memory-port arbiter slice:
//   - default address/data widths
//   - arbiter FSM state encoding (IDLE/ISSUE/WAIT/RESP)
//   - transaction owner encoding (fetch vs. data)
//   - cnt_width(): width of a counter that must hold 0..max_val
// ---------------------------------------------------------------------------
package mips32_pkg;

  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_DW = 32;

  // Arbiter FSM states. Plain constants keep the encoding stable for
  // older tools and for anyone probing the state bits in a waveform.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Which requester owns the transaction currently in flight.
  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  // Width needed to count 0..max_val; never narrower than one bit so a
  // degenerate parameter value still elaborates.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// ---------------------------------------------------------------------------
// arb_starve_ctr
// Counts consecutive data grants made while a fetch request was pending.
// Once the count reaches MAX_D_GRANTS, force_if tells the arbiter to hand
// the next contested grant to the fetch requester.
//
// Ports
//   clk          in   clock, all logic on posedge
//   rst_n        in   synchronous reset, active-low
//   grant_event  in   arbiter is taking an IDLE->ISSUE transition this cycle
//   grant_is_d   in   that grant goes to the data requester
//   if_req       in   fetch request level, sampled with the grant
//   force_if     out  count is saturated: fetch must win the next contest
// ---------------------------------------------------------------------------
module arb_starve_ctr
  import mips32_pkg::*;
#(
  parameter int MAX_D_GRANTS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grant_event,
  input  logic grant_is_d,
  input  logic if_req,
  output logic force_if
);

  localparam int             CW      = cnt_width(MAX_D_GRANTS);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_D_GRANTS);

  logic [CW-1:0] starve_cnt;

  // Only grants move the counter. A data grant while fetch waits extends
  // the run (saturating); a fetch grant, or a data grant with no fetch
  // pending, means fetch is not being starved, so the run restarts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_event) begin
      if (grant_is_d && if_req) begin
        if (starve_cnt != CNT_MAX) begin
          starve_cnt <= starve_cnt + CW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign force_if = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous, word-addressed memory between the
// instruction-fetch path and the load/store path of the mips32 core.
// One transaction is in flight at a time. Data requests win contested
// arbitration unless the fetch side has been passed over MAX_D_GRANTS
// times in a row. Every output is a register.
//
// Transaction timeline (cycle 0 = IDLE cycle in which req is sampled):
//   cycle 1            ISSUE: mem_en (and mem_we for stores)
//   cycles 2..1+LAT    WAIT (loads only): rdata captured in the last one
//   cycle 2 / 2+LAT    RESP: owner ack pulse (store / load)
//   next cycle         IDLE again, req sampled afresh
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst_n      in   synchronous reset, active-low
//   if_req     in   fetch request, held with if_addr until if_ack
//   if_addr    in   fetch word address
//   if_ack     out  1-cycle completion pulse, if_rdata valid
//   if_rdata   out  fetched word (holds until the next fetch completes)
//   d_req      in   data request, held with d_we/d_addr/d_wdata until d_ack
//   d_we       in   1 = store, 0 = load
//   d_addr     in   data word address
//   d_wdata    in   store data
//   d_ack      out  1-cycle completion pulse, d_rdata valid for loads
//   d_rdata    out  load data (holds until the next load completes)
//   mem_en     out  memory strobe, one cycle per transaction
//   mem_we     out  memory write enable, only ever high with mem_en
//   mem_addr   out  memory address, held until the next transaction
//   mem_wdata  out  memory write data, held until the next store
//   mem_rdata  in   memory read data, valid MEM_LAT cycles after mem_en
//   busy       out  FSM is not in IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mips32_pkg::*;
#(
  parameter int AW           = DEFAULT_AW,
  parameter int DW           = DEFAULT_DW,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_GRANTS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int LW = cnt_width(MEM_LAT);

  logic [1:0]    state;
  logic [1:0]    state_next;
  owner_e        owner;
  logic          op_we;
  logic [LW-1:0] lat_cnt;

  logic          grant_event;
  logic          grant_is_d;
  logic          force_if;
  logic          rdata_capture;

  // -------------------------------------------------------------------------
  // Arbitration. Requests are looked at only in IDLE; anything raised while
  // a transaction is in flight is simply held by the requester's handshake.
  // -------------------------------------------------------------------------
  assign grant_event = (state == S_IDLE) && (if_req || d_req);

  // Data wins by default; fetch wins a contest only when starved, and a
  // lone fetch request is granted because d_req is low.
  assign grant_is_d  = d_req && !(if_req && force_if);

  arb_starve_ctr #(
    .MAX_D_GRANTS (MAX_D_GRANTS)
  ) u_starve_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .grant_event (grant_event),
    .grant_is_d  (grant_is_d),
    .if_req      (if_req),
    .force_if    (force_if)
  );

  // Last WAIT cycle: this is the cycle mem_rdata is valid for the load.
  assign rdata_capture = (state == S_WAIT) && (lat_cnt == LW'(1));

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default before the case means every path drives
    // state_next, so no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE:  if (grant_event)   state_next = S_ISSUE;
      S_ISSUE: state_next = op_we ? S_RESP : S_WAIT;
      S_WAIT:  if (rdata_capture) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, payload and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here, so every register in this block
    // updates from pre-edge values regardless of statement order.
    if (!rst_n) begin
      // A transaction in flight is abandoned without an ack; its requester
      // is still holding req and gets served again from IDLE.
      state     <= S_IDLE;
      owner     <= OWNER_IF;
      op_we     <= 1'b0;
      lat_cnt   <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);

      // ISSUE is entered only from a grant, so the strobe is the grant
      // delayed by one cycle and lasts exactly the ISSUE cycle.
      mem_en <= grant_event;
      mem_we <= grant_event && grant_is_d && d_we;

      // RESP is entered only from ISSUE/WAIT, where owner is already valid.
      if_ack <= (state_next == S_RESP) && (owner == OWNER_IF);
      d_ack  <= (state_next == S_RESP) && (owner == OWNER_D);

      // Latch the winner's payload. mem_addr/mem_wdata double as the
      // payload registers, which gives the hold-until-next-ISSUE behaviour
      // for free. Fetches carry no write data, so mem_wdata keeps the
      // last store's value rather than toggling.
      if (grant_event) begin
        owner    <= grant_is_d ? OWNER_D : OWNER_IF;
        op_we    <= grant_is_d && d_we;
        mem_addr <= grant_is_d ? d_addr : if_addr;
        if (grant_is_d) begin
          mem_wdata <= d_wdata;
        end
      end

      // Load latency: armed in ISSUE, counted down through WAIT.
      if (state == S_ISSUE) begin
        lat_cnt <= LW'(MEM_LAT);
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt - LW'(1);
      end

      // Only the owner's read-data register is written.
      if (rdata_capture) begin
        if (owner == OWNER_D) begin
          d_rdata <= mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. Two instances: dut (MEM_LAT=1)
// carries the directed tables, corner sequences and the randomized run
// against a transaction-level model; dut3 (MEM_LAT=3) carries the
// fetch-stream latency sequence.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int MAXG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance signals
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_ack, d_ack, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  // MEM_LAT=3 instance signals
  logic          l3_if_req, l3_d_req, l3_d_we;
  logic [AW-1:0] l3_if_addr, l3_d_addr;
  logic [DW-1:0] l3_d_wdata;
  logic          l3_if_ack, l3_d_ack, l3_mem_en, l3_mem_we, l3_busy;
  logic [DW-1:0] l3_if_rdata, l3_d_rdata, l3_mem_wdata, l3_mem_rdata;
  logic [AW-1:0] l3_mem_addr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(LAT), .MAX_D_GRANTS(MAXG)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(LAT3), .MAX_D_GRANTS(MAXG)
  ) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_ack(l3_if_ack), .if_rdata(l3_if_rdata),
    .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
    .d_ack(l3_d_ack), .d_rdata(l3_d_rdata),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
    .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata), .busy(l3_busy)
  );

  // Power-on memory contents; location 0x10 holds the known test word.
  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  // Memory for the main instance: 256 words indexed by the low address
  // byte, 1-cycle read latency; rdata is garbage except the cycle after a
  // read strobe so a mistimed capture is visible.
  logic [31:0] dmem [256];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_word(8'(i));
    end else if (mem_en && mem_we) begin
      dmem[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= (mem_en && !mem_we) ? dmem[mem_addr[7:0]] : 32'hBAD0_0BAD;
  end

  // Read-only memory for the MEM_LAT=3 instance: three-stage pipeline.
  logic [31:0] p0, p1, p2;
  always @(posedge clk) begin
    p0 <= (l3_mem_en && !l3_mem_we) ? init_word(l3_mem_addr[7:0]) : 32'hBAD3_3BAD;
    p1 <= p0;
    p2 <= p1;
  end
  assign l3_mem_rdata = p2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " if_ack"},    if_ack,    0);
    check({tag, " if_rdata"},  if_rdata,  0);
    check({tag, " d_ack"},     d_ack,     0);
    check({tag, " d_rdata"},   d_rdata,   0);
    check({tag, " mem_en"},    mem_en,    0);
    check({tag, " mem_we"},    mem_we,    0);
    check({tag, " mem_addr"},  mem_addr,  0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
    check({tag, " busy"},      busy,      0);
  endtask

  // ------------------------------------------------------------------------
  // Directed single-transaction vectors (MEM_LAT=1)
  // ------------------------------------------------------------------------
  typedef struct {
    bit          use_if;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_en;
    int          exp_ack;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v, output int en_cyc, output int ack_cyc,
                         output logic [31:0] a_addr, output logic a_we,
                         output logic [31:0] a_wdata, output logic [31:0] a_rdata,
                         output int stray);
    logic own_ack, other_ack;
    en_cyc = -1; ack_cyc = -1; a_addr = '0; a_we = 1'b0;
    a_wdata = '0; a_rdata = '0; stray = 0;
    if (v.use_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end
    for (int n = 1; n <= 10; n++) begin
      tick();
      own_ack   = v.use_if ? if_ack : d_ack;
      other_ack = v.use_if ? d_ack  : if_ack;
      if (mem_we && !mem_en) stray++;
      if (other_ack) stray++;
      if (mem_en) begin
        if (en_cyc < 0) begin
          en_cyc = n; a_addr = mem_addr; a_we = mem_we; a_wdata = mem_wdata;
        end else begin
          stray++;
        end
      end
      if (own_ack) begin
        if (ack_cyc < 0) begin
          ack_cyc = n;
          a_rdata = v.use_if ? if_rdata : d_rdata;
          if_req  = 1'b0;
          d_req   = 1'b0;
        end else begin
          stray++;
        end
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  // ------------------------------------------------------------------------
  // Randomized run against a transaction-level model. The model knows only
  // the rules: when the port is free, who wins, how many cycles a load or a
  // store occupies, and what the memory holds.
  // ------------------------------------------------------------------------
  task automatic new_if_req();
    if_addr = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
  endtask

  task automatic new_d_req();
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
    d_wdata = $urandom;
  endtask

  task automatic random_test(input int ncyc);
    logic [31:0] ref_mem [256];
    int          next_free, en_cyc, ack_cyc, streak, lat, obs;
    bit          t_is_if, t_we, started, pick_if;
    logic [31:0] t_addr, t_wdata, t_rdata, e_if_rdata, e_d_rdata;

    next_free = 0; en_cyc = -1; ack_cyc = -1; streak = 0;
    t_is_if = 1'b0; t_we = 1'b0; started = 1'b0;
    t_addr = '0; t_wdata = '0; t_rdata = '0;
    e_if_rdata = '0; e_d_rdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));

    for (int c = 0; c < ncyc; c++) begin
      // Grant decision for the IDLE cycle c
      if (c >= next_free && (if_req || d_req)) begin
        pick_if = if_req && (!d_req || streak == MAXG);
        t_is_if = pick_if;
        t_we    = pick_if ? 1'b0 : d_we;
        t_addr  = pick_if ? if_addr : d_addr;
        if (!pick_if) t_wdata = d_wdata;
        lat       = t_we ? 0 : LAT;
        en_cyc    = c + 1;
        ack_cyc   = c + 2 + lat;
        next_free = c + 3 + lat;
        if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
        else      t_rdata = ref_mem[t_addr[7:0]];
        if (!pick_if && if_req) streak = (streak == MAXG) ? MAXG : streak + 1;
        else                    streak = 0;
        started = 1'b1;
      end

      tick();
      obs = c + 1;
      if (obs == ack_cyc && !t_we) begin
        if (t_is_if) e_if_rdata = t_rdata;
        else         e_d_rdata  = t_rdata;
      end

      check("rnd mem_en",   mem_en, obs == en_cyc);
      check("rnd mem_we",   mem_we, (obs == en_cyc) && t_we);
      if (started) check("rnd mem_addr", mem_addr, t_addr);
      if (obs == en_cyc && t_we) check("rnd mem_wdata", mem_wdata, t_wdata);
      check("rnd if_ack",   if_ack, (obs == ack_cyc) && t_is_if);
      check("rnd d_ack",    d_ack,  (obs == ack_cyc) && !t_is_if);
      check("rnd if_rdata", if_rdata, e_if_rdata);
      check("rnd d_rdata",  d_rdata,  e_d_rdata);
      check("rnd busy",     busy, obs < next_free);

      // Requester behaviour: the acked side drops or presents a new request
      // in the following IDLE cycle; an idle side may raise a request at any
      // time, including while the port is busy.
      if (obs == ack_cyc) begin
        if (t_is_if) begin
          if_req = ($urandom_range(0, 9) < 6);
          if (if_req) new_if_req();
        end else begin
          d_req = ($urandom_range(0, 9) < 6);
          if (d_req) new_d_req();
        end
      end
      if (!if_req && $urandom_range(0, 9) < 4) begin if_req = 1'b1; new_if_req(); end
      if (!d_req  && $urandom_range(0, 9) < 4) begin d_req  = 1'b1; new_d_req();  end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  // ------------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------------
  initial begin
    int          en_cyc, ack_cyc, stray, base;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_we;
    logic [1:0]  grants [$];
    logic [1:0]  exp_grant;
    int          acks [3];
    int          nack;

    rst_n = 1'b0; mem_init = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    l3_if_req = 1'b0; l3_if_addr = '0; l3_d_req = 1'b0; l3_d_we = 1'b0;
    l3_d_addr = '0; l3_d_wdata = '0;
    tick();
    mem_init = 1'b0;
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // ---- Table-driven single transactions ----
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          1, 3, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678,  1, 2, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,          1, 3, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          1, 3, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hA5A5_5A5A,  1, 2, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,          1, 3, 32'hA5A5_5A5A};
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], en_cyc, ack_cyc, a_addr, a_we, a_wdata, a_rdata, stray);
      check($sformatf("vec%0d en_cycle", i),  en_cyc,  vecs[i].exp_en);
      check($sformatf("vec%0d ack_cycle", i), ack_cyc, vecs[i].exp_ack);
      check($sformatf("vec%0d mem_addr", i),  a_addr,  vecs[i].addr);
      check($sformatf("vec%0d mem_we", i),    a_we,    vecs[i].we);
      if (vecs[i].we) check($sformatf("vec%0d mem_wdata", i), a_wdata, vecs[i].wdata);
      else            check($sformatf("vec%0d rdata", i),     a_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d stray_events", i), stray, 0);
    end

    // ---- Reset in the middle of a load ----
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    tick();
    check("rstmid issue mem_en", mem_en, 1);
    tick();
    check("rstmid wait busy", busy, 1);
    check("rstmid wait d_ack", d_ack, 0);
    rst_n = 1'b0;
    tick();
    check_zero("rstmid");
    rst_n = 1'b1;
    en_cyc = -1; ack_cyc = -1; a_rdata = '0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (mem_en && en_cyc < 0) en_cyc = n;
      if (d_ack && ack_cyc < 0) begin
        ack_cyc = n; a_rdata = d_rdata; d_req = 1'b0;
      end
    end
    d_req = 1'b0;
    check("rstmid reserve en_cycle",  en_cyc,  1);
    check("rstmid reserve ack_cycle", ack_cyc, 2 + LAT);
    check("rstmid reserve d_rdata",   a_rdata, 32'hDEADBEEF);

    // ---- Both requesters always pending: starvation pattern ----
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    grants.delete();
    for (int n = 0; n < 80 && grants.size() < 10; n++) begin
      tick();
      if (mem_en) grants.push_back((mem_addr == 32'h100) ? 2'd1 : 2'd0);
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_grant = ((i % 5) == 4) ? 2'd1 : 2'd0;
      check($sformatf("starve grant%0d is_fetch", i),
            (i < grants.size()) ? grants[i] : 2'd2, exp_grant);
    end
    for (int i = 0; i < 8; i++) tick();

    // ---- Data request raised in a fetch's RESP cycle ----
    do_reset();
    if_req = 1'b1; if_addr = 32'h30;
    tick();
    tick();
    tick();
    check("resp_req if_ack", if_ack, 1);
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h55;
    tick();
    check("resp_req idle mem_en", mem_en, 0);
    check("resp_req idle busy", busy, 0);
    d_addr = 32'h66;
    tick();
    check("resp_req issue mem_en", mem_en, 1);
    check("resp_req issue mem_addr", mem_addr, 32'h66);
    tick();
    tick();
    check("resp_req d_ack", d_ack, 1);
    check("resp_req d_rdata", d_rdata, init_word(8'h66));
    d_req = 1'b0;
    tick();

    // ---- Fetch stream with MEM_LAT=3 ----
    l3_if_req = 1'b1; l3_if_addr = 32'h0;
    nack = 0; stray = 0;
    for (int k = 0; k < 3; k++) acks[k] = -1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (n <= 17) check($sformatf("lat3 busy c%0d", n), l3_busy, (n % 6) != 0);
      if (l3_d_ack) stray++;
      if (l3_if_ack) begin
        if (nack < 3) begin
          acks[nack] = n;
          check($sformatf("lat3 rdata%0d", nack), l3_if_rdata, init_word(l3_if_addr[7:0]));
        end
        nack++;
        if (nack < 3) l3_if_addr = l3_if_addr + 32'd1;
        else          l3_if_req  = 1'b0;
      end
    end
    l3_if_req = 1'b0;
    for (int k = 0; k < 3; k++) check($sformatf("lat3 ack%0d cycle", k), acks[k], 5 + 6 * k);
    check("lat3 ack_count", nack, 3);
    check("lat3 stray d_ack", stray, 0);

    // ---- Randomized run ----
    do_reset();
    mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
    random_test(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
